// File: rtl/cs_resolve_reduce.sv
// Resolves a carry-save (C, S, carry) result to binary with a chunked carry-propagate
// adder, applying the final conditional subtraction of m in the same LSB-first pass.
module cs_resolve_reduce #(
  parameter int WIDTH = 1024,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH+1:0] in_C,
  input  logic [WIDTH:0]   in_S,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] in_m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             range_err,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + 2 + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q;
  logic [KW-1:0]     k_q;
  logic [PW-1:0]     c_q, s_q, m_q;
  logic [PW-1:0]     sum_q, diff_q;
  logic              cy_q, bw_q;
  logic [WIDTH-1:0]  result_q;
  logic              range_err_q;
  logic              out_valid_q;

  logic [PW-1:0]     sum_d, diff_d, sel_d;
  logic              cy_d, bw_d;
  logic [CHUNK:0]    add_w, sub_w;
  int                base;

  // The borrow chain consumes the sum chunk produced in the same cycle, so the
  // subtraction needs no second pass over the data.
  always_comb begin
    base   = CHUNK * int'(k_q);
    add_w  = {1'b0, c_q[base +: CHUNK]} + {1'b0, s_q[base +: CHUNK]}
           + {{CHUNK{1'b0}}, cy_q};
    sub_w  = {1'b0, add_w[CHUNK-1:0]} - {1'b0, m_q[base +: CHUNK]}
           - {{CHUNK{1'b0}}, bw_q};
    sum_d  = sum_q;
    diff_d = diff_q;
    sum_d[base +: CHUNK]  = add_w[CHUNK-1:0];
    diff_d[base +: CHUNK] = sub_w[CHUNK-1:0];
    cy_d   = add_w[CHUNK];
    bw_d   = sub_w[CHUNK];
    sel_d  = bw_d ? sum_d : diff_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      m_q         <= '0;
      sum_q       <= '0;
      diff_q      <= '0;
      cy_q        <= 1'b0;
      bw_q        <= 1'b0;
      result_q    <= '0;
      range_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            c_q     <= PW'(in_C);
            s_q     <= PW'(in_S);
            m_q     <= PW'(in_m);
            cy_q    <= carry_in;
            bw_q    <= 1'b0;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q  <= sum_d;
          diff_q <= diff_d;
          cy_q   <= cy_d;
          bw_q   <= bw_d;
          if (k_q == KLAST) begin
            // Final borrow clear means V >= M, so the difference bank is selected.
            k_q         <= '0;
            result_q    <= sel_d[WIDTH-1:0];
            range_err_q <= |sel_d[PW-1:WIDTH];
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_cs_resolve_reduce.sv
// Directed self-checking bench for cs_resolve_reduce: reset state, reduction vectors,
// chunk carry/borrow boundaries, range error, backpressure and mid-operation reset.
module tb_cs_resolve_reduce;

  localparam int W = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic           start_valid;
  logic           start_ready;
  logic [W+1:0]   in_C;
  logic [W:0]     in_S;
  logic           carry_in;
  logic [W-1:0]   in_m;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           range_err;
  logic           busy;

  int tests = 0;
  int fails = 0;

  cs_resolve_reduce #(.WIDTH(W), .CHUNK(64)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .in_C(in_C), .in_S(in_S), .carry_in(carry_in), .in_m(in_m),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one operation when the block is idle, scrambles the inputs after the
  // accept edge, and reports the cycle index (accept cycle = 0) where out_valid shows.
  task automatic run_op(input logic [W+1:0] c, input logic [W:0] s, input logic ci,
                        input logic [W-1:0] m, output logic [W-1:0] res,
                        output logic rerr, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!start_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    in_C = c; in_S = s; carry_in = ci; in_m = m;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    in_C = '1; in_S = '1; carry_in = 1'b1; in_m = '0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res  = result;
    rerr = range_err;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; out_ready = 1'b1;
    in_C = '0; in_S = '0; carry_in = 1'b0; in_m = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (start_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_start_ready: got %b exp 1", start_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b exp 0", busy); end
    tests++; if (result !== '0) begin fails++; $display("[TB] FAIL reset_result: got %h exp 0 (low 128 bits)", result[127:0]); end
    tests++; if (range_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_range_err: got %b exp 0", range_err); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_vectors();
    logic [W+1:0] tc [7];
    logic [W:0]   ts [7];
    logic         tci[7];
    logic [W-1:0] tm [7];
    logic [W-1:0] te [7];
    logic         terr[7];
    logic [W-1:0] res;
    logic         rerr;
    int           lat;
    // V < M passes through unchanged
    tc[0] = '0; ts[0] = 5; tci[0] = 1'b0; tm[0] = 7; te[0] = 5; terr[0] = 1'b0;
    // V = 8 >= 7 subtracts once
    tc[1] = 3; ts[1] = 4; tci[1] = 1'b1; tm[1] = 7; te[1] = 1; terr[1] = 1'b0;
    // carry out of chunk 0 into chunk 1
    tc[2] = '0; tc[2][63:0] = '1; ts[2] = 1; tci[2] = 1'b0;
    tm[2] = '0; tm[2][W-1] = 1'b1; tm[2][0] = 1'b1;
    te[2] = '0; te[2][64] = 1'b1; terr[2] = 1'b0;
    // V == M with all-ones modulus: borrow runs across every chunk
    tm[3] = '1; tc[3] = {2'b00, tm[3]}; ts[3] = '0; tci[3] = 1'b0; te[3] = '0; terr[3] = 1'b0;
    // V = 2^1025, M = 3: out of range
    tc[4] = '0; tc[4][W+1] = 1'b1; ts[4] = '0; tci[4] = 1'b0; tm[4] = 3;
    te[4] = '1; te[4] = te[4] - 2; terr[4] = 1'b1;
    // V - M = 2^1024 exactly: smallest out-of-range value
    tc[5] = {2'b00, {W{1'b1}}}; ts[5] = {1'b0, {W{1'b1}}}; tci[5] = 1'b1; tm[5] = '1;
    te[5] = '0; terr[5] = 1'b1;
    // V - M = 2^1024 - 1: largest in-range value
    tc[6] = {2'b00, {W{1'b1}}}; ts[6] = 5; tci[6] = 1'b0; tm[6] = 5;
    te[6] = '1; terr[6] = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(tc[i], ts[i], tci[i], tm[i], res, rerr, lat);
      tests++; if (lat !== 18) begin fails++; $display("[TB] FAIL vec%0d_latency: got %0d exp 18", i, lat); end
      tests++; if (res !== te[i]) begin fails++; $display("[TB] FAIL vec%0d_result: got %h exp %h (low 128 bits)", i, res[127:0], te[i][127:0]); end
      tests++; if (rerr !== terr[i]) begin fails++; $display("[TB] FAIL vec%0d_range_err: got %b exp %b", i, rerr, terr[i]); end
    end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL after_transfer_valid: got %b exp 0", out_valid); end
    tests++; if (start_ready !== 1'b1) begin fails++; $display("[TB] FAIL after_transfer_ready: got %b exp 1", start_ready); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res;
    logic         rerr;
    int           lat;
    out_ready = 1'b0;
    run_op('0, 9, 1'b0, 7, res, rerr, lat);
    tests++; if (lat !== 18) begin fails++; $display("[TB] FAIL bp_latency: got %0d exp 18", lat); end
    tests++; if (res !== 2) begin fails++; $display("[TB] FAIL bp_result: got %h exp 2 (low 128 bits)", res[127:0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = (i == 1);
      in_C = 3; in_S = 4; carry_in = 1'b0; in_m = 5;
      @(posedge clk); #1;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_hold_valid%0d: got %b exp 1", i, out_valid); end
      tests++; if (result !== 2) begin fails++; $display("[TB] FAIL bp_hold_result%0d: got %h exp 2 (low 128 bits)", i, result[127:0]); end
      tests++; if (start_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_start_ready%0d: got %b exp 0", i, start_ready); end
    end
    @(negedge clk);
    start_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_release_valid: got %b exp 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_release_busy: got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] res;
    logic         rerr;
    int           lat;
    int           seen = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_C = '0; in_S = 5; carry_in = 1'b0; in_m = 7;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL midrun_busy: got %b exp 1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    tests++; if (start_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrun_reset_ready: got %b exp 1", start_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrun_reset_busy: got %b exp 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("[TB] FAIL midrun_no_valid: got %0d valid cycles exp 0", seen); end
    run_op(3, 4, 1'b1, 7, res, rerr, lat);
    tests++; if (lat !== 18) begin fails++; $display("[TB] FAIL post_reset_latency: got %0d exp 18", lat); end
    tests++; if (res !== 1) begin fails++; $display("[TB] FAIL post_reset_result: got %h exp 1 (low 128 bits)", res[127:0]); end
    tests++; if (rerr !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_range_err: got %b exp 0", rerr); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
